// File: rtl/axi_ctrl_pkg.sv
// Shared types and response codes for the AXI interconnect control blocks.
package axi_ctrl_pkg;

  typedef enum logic [2:0] {ARB, WRITE, WRESP, READ, TOUT} sched_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_EXOKAY = 2'b01;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first requester at or above i_ptr,
// otherwise the lowest-index requester.
module rr_pick #(
  parameter int NUM_M = 2,
  parameter int IDW   = 1
) (
  input  logic [NUM_M-1:0] i_req,
  input  logic [IDW-1:0]   i_ptr,
  output logic [NUM_M-1:0] o_pick,
  output logic [IDW-1:0]   o_idx
);

  logic [NUM_M-1:0] w_masked;
  logic             w_found;

  always_comb begin
    // NOTE: every output gets a default before any branch so no latch is inferred.
    w_masked = '0;
    o_pick   = '0;
    o_idx    = '0;
    w_found  = 1'b0;
    for (int i = 0; i < NUM_M; i++) begin
      w_masked[i] = i_req[i] && (i >= int'(i_ptr));
    end
    // Masked chain wins; the unmasked chain only supplies the wrap-around.
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && w_masked[i]) begin
        o_pick[i] = 1'b1;
        o_idx     = IDW'(i);
        w_found   = 1'b1;
      end
    end
    for (int i = 0; i < NUM_M; i++) begin
      if (!w_found && i_req[i]) begin
        o_pick[i] = 1'b1;
        o_idx     = IDW'(i);
        w_found   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/axi_bus_sched.sv
// Round-robin bus-ownership scheduler: grants the slave port to one master for
// one whole AXI transaction, with a watchdog that aborts stalled transactions.
module axi_bus_sched
  import axi_ctrl_pkg::*;
#(
  parameter int NUM_M       = 2,
  parameter int TIMEOUT_CYC = 256,
  parameter int IDW         = (NUM_M > 2) ? $clog2(NUM_M) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NUM_M-1:0] m_awvalid,
  input  logic [NUM_M-1:0] m_arvalid,
  input  logic             aw_fire,
  input  logic             wlast_fire,
  input  logic             b_fire,
  input  logic             ar_fire,
  input  logic             rlast_fire,
  input  logic [1:0]       resp,
  input  logic             abort_ack,
  output logic [NUM_M-1:0] gnt,
  output logic [IDW-1:0]   gnt_id,
  output logic             wr_sel,
  output logic             abort,
  output logic [7:0]       err_cnt
);

  localparam int             TW        = $clog2(TIMEOUT_CYC);
  localparam logic [TW-1:0]  TOUT_LAST = TW'(TIMEOUT_CYC - 1);
  localparam logic [IDW-1:0] LAST_ID   = IDW'(NUM_M - 1);

  sched_state_e     r_state, w_state_nxt;
  logic [NUM_M-1:0] r_gnt, w_gnt_nxt;
  logic [IDW-1:0]   r_gnt_id, w_gnt_id_nxt;
  logic [IDW-1:0]   r_ptr, w_ptr_nxt;
  logic             r_wr_sel, w_wr_sel_nxt;
  logic             r_aw_done, w_aw_done_nxt;
  logic             r_wl_done, w_wl_done_nxt;
  logic             r_ar_done, w_ar_done_nxt;
  logic [TW-1:0]    r_tout_cnt, w_tout_cnt_nxt;
  logic [7:0]       r_err_cnt, w_err_cnt_nxt;

  logic [NUM_M-1:0] w_req, w_pick;
  logic [IDW-1:0]   w_pick_id;
  logic             w_any_fire, w_resp_err, w_release, w_err_inc;
  logic             w_aw_seen, w_wl_seen;

  assign w_req      = m_awvalid | m_arvalid;
  assign w_any_fire = aw_fire | wlast_fire | b_fire | ar_fire | rlast_fire;
  assign w_aw_seen  = r_aw_done | aw_fire;
  assign w_wl_seen  = r_wl_done | wlast_fire;

  rr_pick #(.NUM_M(NUM_M), .IDW(IDW)) u_rr_pick (
    .i_req  (w_req),
    .i_ptr  (r_ptr),
    .o_pick (w_pick),
    .o_idx  (w_pick_id)
  );

  always_comb begin
    case (resp)
      RESP_OKAY, RESP_EXOKAY:   w_resp_err = 1'b0;
      RESP_SLVERR, RESP_DECERR: w_resp_err = 1'b1;
      default:                  w_resp_err = 1'b0;
    endcase
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_gnt_nxt      = r_gnt;
    w_gnt_id_nxt   = r_gnt_id;
    w_ptr_nxt      = r_ptr;
    w_wr_sel_nxt   = r_wr_sel;
    w_aw_done_nxt  = r_aw_done;
    w_wl_done_nxt  = r_wl_done;
    w_ar_done_nxt  = r_ar_done;
    w_tout_cnt_nxt = r_tout_cnt;
    w_err_cnt_nxt  = r_err_cnt;
    w_release      = 1'b0;
    w_err_inc      = 1'b0;

    // Watchdog runs in every ownership phase; transitions below only occur on a
    // fire, so they never collide with a timeout.
    if (r_state inside {WRITE, WRESP, READ}) begin
      w_tout_cnt_nxt = w_any_fire ? '0 : r_tout_cnt + 1'b1;
      if (r_tout_cnt == TOUT_LAST && !w_any_fire) begin
        w_state_nxt = TOUT;
        w_err_inc   = 1'b1;
      end
    end

    case (r_state)
      ARB: begin
        if (|w_req) begin
          w_gnt_nxt      = w_pick;
          w_gnt_id_nxt   = w_pick_id;
          w_wr_sel_nxt   = |(m_awvalid & w_pick);
          w_state_nxt    = (|(m_awvalid & w_pick)) ? WRITE : READ;
          w_aw_done_nxt  = 1'b0;
          w_wl_done_nxt  = 1'b0;
          w_ar_done_nxt  = 1'b0;
          w_tout_cnt_nxt = '0;
        end
      end
      WRITE: begin
        w_aw_done_nxt = w_aw_seen;
        w_wl_done_nxt = w_wl_seen;
        if (w_aw_seen && w_wl_seen) begin
          w_state_nxt    = WRESP;
          w_tout_cnt_nxt = '0;
        end
      end
      WRESP: w_release = b_fire;
      READ: begin
        if (!(ar_fire && rlast_fire)) begin
          if (!r_ar_done && ar_fire) w_ar_done_nxt = 1'b1;
          else if (r_ar_done && rlast_fire) w_release = 1'b1;
        end
      end
      TOUT:    w_release = abort_ack;
      default: w_state_nxt = ARB;
    endcase

    if (w_release) begin
      w_ptr_nxt    = (r_gnt_id == LAST_ID) ? '0 : r_gnt_id + 1'b1;
      w_gnt_nxt    = '0;
      w_gnt_id_nxt = '0;
      w_wr_sel_nxt = 1'b0;
      w_state_nxt  = ARB;
      if (r_state != TOUT && w_resp_err) w_err_inc = 1'b1;
    end

    if (w_err_inc && r_err_cnt != 8'hFF) w_err_cnt_nxt = r_err_cnt + 8'd1;
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      r_state    <= ARB;
      r_gnt      <= '0;
      r_gnt_id   <= '0;
      r_ptr      <= '0;
      r_wr_sel   <= 1'b0;
      r_aw_done  <= 1'b0;
      r_wl_done  <= 1'b0;
      r_ar_done  <= 1'b0;
      r_tout_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_gnt      <= w_gnt_nxt;
      r_gnt_id   <= w_gnt_id_nxt;
      r_ptr      <= w_ptr_nxt;
      r_wr_sel   <= w_wr_sel_nxt;
      r_aw_done  <= w_aw_done_nxt;
      r_wl_done  <= w_wl_done_nxt;
      r_ar_done  <= w_ar_done_nxt;
      r_tout_cnt <= w_tout_cnt_nxt;
      r_err_cnt  <= w_err_cnt_nxt;
    end
  end

  assign gnt     = r_gnt;
  assign gnt_id  = r_gnt_id;
  assign wr_sel  = r_wr_sel;
  assign abort   = (r_state == TOUT);
  assign err_cnt = r_err_cnt;

endmodule

// File: tb/tb_axi_bus_sched.sv
// Randomized self-checking bench for axi_bus_sched against a transaction-level
// round-robin / watchdog / error-count model.
module tb_axi_bus_sched;

  localparam int NUM_M       = 3;
  localparam int TIMEOUT_CYC = 16;

  logic             clk = 1'b0;
  logic             rst;
  logic [NUM_M-1:0] m_awvalid, m_arvalid;
  logic             aw_fire, wlast_fire, b_fire, ar_fire, rlast_fire, abort_ack;
  logic [1:0]       resp;
  logic [NUM_M-1:0] gnt;
  logic [1:0]       gnt_id;
  logic             wr_sel, abort;
  logic [7:0]       err_cnt;

  int checks   = 0;
  int failures = 0;
  int m_ptr    = 0;
  int m_err    = 0;

  axi_bus_sched #(.NUM_M(NUM_M), .TIMEOUT_CYC(TIMEOUT_CYC)) dut (
    .clk(clk), .rst(rst),
    .m_awvalid(m_awvalid), .m_arvalid(m_arvalid),
    .aw_fire(aw_fire), .wlast_fire(wlast_fire), .b_fire(b_fire),
    .ar_fire(ar_fire), .rlast_fire(rlast_fire), .resp(resp),
    .abort_ack(abort_ack),
    .gnt(gnt), .gnt_id(gnt_id), .wr_sel(wr_sel), .abort(abort), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL global_timeout checks=%0d failures=%0d", checks, failures);
    $fatal(1, "bench did not finish");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic pulse(input logic f_aw, f_wl, f_b, f_ar, f_rl, f_ack, input logic [1:0] rsp);
    aw_fire = f_aw; wlast_fire = f_wl; b_fire = f_b;
    ar_fire = f_ar; rlast_fire = f_rl; abort_ack = f_ack; resp = rsp;
    cyc();
    aw_fire = 0; wlast_fire = 0; b_fire = 0;
    ar_fire = 0; rlast_fire = 0; abort_ack = 0; resp = 2'b00;
  endtask

  function automatic int pick_model(input logic [NUM_M-1:0] req);
    for (int k = 0; k < NUM_M; k++) begin
      int j = (m_ptr + k) % NUM_M;
      if (req[j]) return j;
    end
    return 0;
  endfunction

  task automatic held(input int win);
    check("hold_gnt", 32'(gnt), 32'(1) << win);
    check("hold_abort", 32'(abort), 32'(0));
  endtask

  task automatic hold(input int n, input int win);
    repeat (n) begin
      cyc();
      held(win);
    end
  endtask

  task automatic grant(input logic [NUM_M-1:0] aw, ar, output int win);
    m_awvalid = aw;
    m_arvalid = ar;
    win = pick_model(aw | ar);
    cyc();
    check("gnt", 32'(gnt), 32'(1) << win);
    check("gnt_id", 32'(gnt_id), 32'(win));
    check("wr_sel", 32'(wr_sel), 32'(aw[win]));
    check("abort_idle", 32'(abort), 32'(0));
  endtask

  task automatic finish_txn(input int win, input logic [1:0] rsp, input logic is_wr);
    pulse(1'b0, 1'b0, is_wr, 1'b0, !is_wr, 1'b0, rsp);
    m_ptr = (win + 1) % NUM_M;
    if (rsp >= 2'b10 && m_err < 255) m_err++;
    check("rel_gnt", 32'(gnt), 32'(0));
    check("rel_id", 32'(gnt_id), 32'(0));
    check("err_cnt", 32'(err_cnt), 32'(m_err));
  endtask

  // order: 0 = AW and WLAST together, 1 = AW first, 2 = WLAST first.
  task automatic txn(input logic [NUM_M-1:0] aw, ar, input int g0, g1, g2, order,
                     input logic [1:0] rsp);
    int win;
    grant(aw, ar, win);
    hold(g0, win);
    if (aw[win]) begin
      case (order)
        0: begin pulse(1, 1, 0, 0, 0, 0, 2'b00); held(win); end
        1: begin
          pulse(1, 0, 0, 0, 0, 0, 2'b00); held(win); hold(g1, win);
          pulse(0, 1, 0, 0, 0, 0, 2'b00); held(win);
        end
        default: begin
          pulse(0, 1, 0, 0, 0, 0, 2'b00); held(win); hold(g1, win);
          pulse(1, 0, 0, 0, 0, 0, 2'b00); held(win);
        end
      endcase
      hold(g2, win);
      finish_txn(win, rsp, 1'b1);
    end else begin
      pulse(0, 0, 0, 1, 0, 0, 2'b00); held(win);
      hold(g1, win);
      finish_txn(win, rsp, 1'b0);
    end
  endtask

  task automatic tout_txn(input logic [NUM_M-1:0] aw, ar, input logic first_fire,
                          input int ack_delay);
    int win;
    grant(aw, ar, win);
    if (first_fire) begin
      pulse(aw[win], 0, 0, !aw[win], 0, 0, 2'b00);
      held(win);
    end
    for (int i = 1; i <= TIMEOUT_CYC; i++) begin
      cyc();
      check("wd_abort", 32'(abort), 32'(i == TIMEOUT_CYC));
      check("wd_gnt", 32'(gnt), 32'(1) << win);
    end
    if (m_err < 255) m_err++;
    check("wd_err", 32'(err_cnt), 32'(m_err));
    repeat (ack_delay) begin
      cyc();
      check("tout_abort", 32'(abort), 32'(1));
      check("tout_gnt", 32'(gnt), 32'(1) << win);
    end
    pulse(0, 0, 0, 0, 0, 1, 2'b00);
    m_ptr = (win + 1) % NUM_M;
    check("ack_abort", 32'(abort), 32'(0));
    check("ack_gnt", 32'(gnt), 32'(0));
    check("ack_err", 32'(err_cnt), 32'(m_err));
  endtask

  initial begin
    int win;
    logic [NUM_M-1:0] aw, ar;

    rst = 1; m_awvalid = '0; m_arvalid = '0;
    aw_fire = 0; wlast_fire = 0; b_fire = 0; ar_fire = 0; rlast_fire = 0;
    abort_ack = 0; resp = 2'b00;
    cyc(); cyc();
    check("rst_gnt", 32'(gnt), 32'(0));
    check("rst_gnt_id", 32'(gnt_id), 32'(0));
    check("rst_wr_sel", 32'(wr_sel), 32'(0));
    check("rst_abort", 32'(abort), 32'(0));
    check("rst_err", 32'(err_cnt), 32'(0));
    rst = 0;

    // Single write from master 0.
    txn(3'b001, 3'b000, 0, 0, 0, 0, 2'b00);

    // Masters 0 and 1 requesting continuously: strict alternation, one dead cycle.
    for (int i = 0; i < 10; i++) begin
      grant(3'b011, 3'b000, win);
      check("alt", 32'(gnt_id), 32'((i + 1) % 2));
      pulse(1, 1, 0, 0, 0, 0, 2'b00);
      finish_txn(win, 2'b00, 1'b1);
    end

    // Master 1 with write and read pending: write first, then the read.
    grant(3'b010, 3'b010, win);
    check("w_first", 32'(wr_sel), 32'(1));
    pulse(1, 1, 0, 0, 0, 0, 2'b00);
    finish_txn(win, 2'b00, 1'b1);
    grant(3'b000, 3'b010, win);
    check("r_second", 32'(wr_sel), 32'(0));
    pulse(0, 0, 0, 1, 0, 0, 2'b00);
    finish_txn(win, 2'b00, 1'b0);

    // WLAST two cycles ahead of AW; a B in WRITE must not release the grant.
    grant(3'b001, 3'b000, win);
    pulse(0, 1, 0, 0, 0, 0, 2'b00); held(win);
    pulse(0, 0, 1, 0, 0, 0, 2'b00); held(win);
    pulse(1, 0, 0, 0, 0, 0, 2'b00); held(win);
    finish_txn(win, 2'b10, 1'b1);
    check("err_one", 32'(err_cnt), 32'(1));

    // Read stalls after AR until the watchdog fires.
    tout_txn(3'b000, 3'b100, 1'b1, 3);

    // Reset while in WRESP.
    grant(3'b100, 3'b000, win);
    pulse(1, 1, 0, 0, 0, 0, 2'b00);
    rst = 1; cyc(); rst = 0;
    m_ptr = 0; m_err = 0;
    check("mid_rst_gnt", 32'(gnt), 32'(0));
    check("mid_rst_id", 32'(gnt_id), 32'(0));
    check("mid_rst_err", 32'(err_cnt), 32'(0));
    check("mid_rst_abort", 32'(abort), 32'(0));
    txn(3'b110, 3'b000, 1, 1, 1, 1, 2'b00);

    // Randomized traffic, stray fires in ARB, occasional watchdog aborts.
    for (int n = 0; n < 60; n++) begin
      m_awvalid = '0; m_arvalid = '0;
      repeat ($urandom_range(0, 2)) begin
        pulse(1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
              1'($urandom), 1'($urandom), 2'($urandom));
        check("arb_idle", 32'(gnt), 32'(0));
      end
      aw = NUM_M'($urandom);
      ar = NUM_M'($urandom);
      if ((aw | ar) == '0) aw = NUM_M'(1) << $urandom_range(0, NUM_M - 1);
      if ($urandom_range(0, 7) == 0)
        tout_txn(aw, ar, 1'($urandom), $urandom_range(0, 3));
      else
        txn(aw, ar, $urandom_range(0, TIMEOUT_CYC - 2), $urandom_range(0, TIMEOUT_CYC - 2),
            $urandom_range(0, TIMEOUT_CYC - 2), $urandom_range(0, 2), 2'($urandom));
    end

    // Error counter saturation.
    for (int n = 0; n < 260; n++) txn(3'b001, 3'b000, 0, 0, 0, 0, 2'b11);
    check("err_sat", 32'(err_cnt), 32'(255));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/axi_bus_sched.md
# axi_bus_sched

Round-robin bus-ownership scheduler for the shared AXI interconnect. It arbitrates the single slave port between NUM_M masters and holds the grant for one complete write (AW+W+B) or read (AR+R) transaction. It releases ownership only on the final response handshake or on a watchdog abort. It sits beside the channel mux and drives its select lines; it carries no data.

## Interface
Parameters:
- NUM_M, 2, number of masters (2..8)
- TIMEOUT_CYC, 256, idle cycles inside a transaction before abort (≥4)
- IDW, max(1,$clog2(NUM_M)), grant index width

Ports:
- clk  in  1  clock; one clock domain
- rst  in  1  reset, synchronous, active-high
- m_awvalid  in  NUM_M  per-master AWVALID (write request)
- m_arvalid  in  NUM_M  per-master ARVALID (read request)
- aw_fire  in  1  AWVALID&AWREADY on the muxed slave side
- wlast_fire  in  1  WVALID&WREADY&WLAST on the muxed slave side
- b_fire  in  1  BVALID&BREADY on the muxed side
- ar_fire  in  1  ARVALID&ARREADY on the muxed side
- rlast_fire  in  1  RVALID&RREADY&RLAST on the muxed side
- resp  in  2  BRESP when b_fire, RRESP when rlast_fire
- abort_ack  in  1  mux has delivered the injected DECERR to the granted master
- gnt  out  NUM_M  one-hot grant; 0 when no owner
- gnt_id  out  IDW  binary index of gnt (0 when gnt==0)
- wr_sel  out  1  1 = write channels routed, 0 = read channels routed
- abort  out  1  mux must sever the slave and inject DECERR to the owner
- err_cnt  out  8  saturating count of SLVERR/DECERR responses and timeouts

## Operation
- States: ARB, WRITE, WRESP, READ, TOUT.
- ARB: req[i] = m_awvalid[i] | m_arvalid[i]. If req≠0, rr_pick selects the first requester at or above the pointer, wrapping to the lowest index. gnt, gnt_id, and wr_sel are registered on the transition. wr_sel=1 if the winner's awvalid is set, so write beats read for the same master. Next state is WRITE or READ. If req==0, stay in ARB with gnt=0.
- WRITE: sticky flags aw_done and wl_done, cleared on entry. W may complete before AW. When both are set (same-cycle fires included), go to WRESP.
- WRESP: on b_fire, go to ARB.
- READ: aw/ar ordering is not tracked. First ar_fire, then rlast_fire, go to ARB. A same-cycle ar_fire+rlast_fire is illegal and ignored.
- Completion (b_fire or rlast_fire): pointer ← (gnt_id+1) mod NUM_M, gnt ← 0. If resp is 2'b10 or 2'b11, err_cnt increments.
- Watchdog: tout_cnt counts cycles in WRITE/WRESP/READ. It clears on any *_fire and on state entry. When tout_cnt==TIMEOUT_CYC-1 with no fire, go to TOUT and increment err_cnt.
- TOUT: abort=1, gnt held. On abort_ack, the pointer advances as on completion and the state goes to ARB.
- Fire inputs for the wrong phase (e.g. b_fire in READ) are ignored. Fires in ARB are ignored.
- err_cnt saturates at 8'hFF.
- Reset mid-transaction: the owner is dropped immediately. The mux must tolerate this.

## Timing
- Reset values: state=ARB, gnt=0, gnt_id=0, wr_sel=0, abort=0, err_cnt=0, pointer=0, tout_cnt=0.
- Grant latency: a request sampled in ARB at cycle t gives gnt valid at t+1.
- Release: a completing fire at cycle t gives gnt=0 at t+1, back in ARB. The earliest new gnt is at t+2, so there is one dead cycle between owners.
- gnt, gnt_id, and wr_sel are stable for the entire ownership. No output is combinational from inputs.
- abort is asserted from the cycle after the timeout through the cycle of abort_ack. It deasserts at the next cycle.
- Back-to-back transactions from one master rotate fairly. With both masters continuously requesting, grants alternate 0,1,0,1.

## Structure
- Package axi_ctrl_pkg holds:
  - state enum sched_state_e {ARB, WRITE, WRESP, READ, TOUT}
  - resp constants RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11
- Sub-module rr_pick: combinational. Inputs req[NUM_M] and pointer[IDW]; outputs one-hot pick and its index. It is built from masked and unmasked fixed-priority chains.
- The FSM, pointer, watchdog, and err_cnt live in axi_bus_sched.

## Test plan
- Reset, then m_awvalid=2'b01 → cycle+1: gnt=01, wr_sel=1. aw_fire, wlast_fire, b_fire with resp=00 → gnt=00 next cycle, pointer=1, err_cnt=0.
- Both masters assert awvalid continuously, ten transactions with immediate fires → gnt sequence 01,10,01,… with exactly one gnt=0 cycle between owners.
- Master 1 asserts awvalid and arvalid together → WRITE first (wr_sel=1). After completion it re-requests, and the read is granted with wr_sel=0.
- Write with wlast_fire two cycles before aw_fire → WRESP entered only after aw_fire. b_fire with resp=2'b10 → err_cnt=1.
- Read granted, ar_fire, then no rlast_fire for TIMEOUT_CYC cycles → abort=1 and err_cnt increments. abort_ack → abort=0 and gnt=0 next cycle, pointer advanced.
- rst pulsed for one cycle while in WRESP → next cycle gnt=0, err_cnt=0, state ARB. A subsequent request is granted normally.
